// File: rtl/sc_tick_scheduler.sv
// sc_tick_scheduler
// Game time base. One shared free-running prescaler produces a base event
// once every 2^PRESCALE_WIDTH clocks while running. Four channels count base
// events against their own programmable period and each emits a one-cycle
// tick when its period elapses. A run/pause/idle FSM gates the time base so
// the game can freeze and resume without losing phase.
//
// Ports
//   SC_TICKSCHED_CLOCK_50         system clock, rising edge
//   SC_TICKSCHED_RESET_InHigh     asynchronous active-high reset
//   SC_TICKSCHED_start_InHigh     pulse: IDLE -> RUN
//   SC_TICKSCHED_stop_InHigh      pulse: RUN/PAUSE -> IDLE (clears phase)
//   SC_TICKSCHED_pause_InHigh     level: freeze time base while high
//   SC_TICKSCHED_cfgWrite_InHigh  strobe: load period of cfgChannel
//   SC_TICKSCHED_cfgChannel_In    channel index for the write
//   SC_TICKSCHED_cfgPeriod_In     period in base events, 0 disables
//   SC_TICKSCHED_tick_Out         registered per-channel tick pulses
//   SC_TICKSCHED_baseTick_Out     base event (prescaler all-ones in RUN)
//   SC_TICKSCHED_state_Out        IDLE=00, RUN=01, PAUSE=10
module sc_tick_scheduler #(
  parameter int PRESCALE_WIDTH = 21,
  parameter int PERIOD_WIDTH   = 4
) (
  input  logic                    SC_TICKSCHED_CLOCK_50,
  input  logic                    SC_TICKSCHED_RESET_InHigh,
  input  logic                    SC_TICKSCHED_start_InHigh,
  input  logic                    SC_TICKSCHED_stop_InHigh,
  input  logic                    SC_TICKSCHED_pause_InHigh,
  input  logic                    SC_TICKSCHED_cfgWrite_InHigh,
  input  logic [1:0]              SC_TICKSCHED_cfgChannel_In,
  input  logic [PERIOD_WIDTH-1:0] SC_TICKSCHED_cfgPeriod_In,
  output logic [3:0]              SC_TICKSCHED_tick_Out,
  output logic                    SC_TICKSCHED_baseTick_Out,
  output logic [1:0]              SC_TICKSCHED_state_Out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  logic clk;
  logic rst;
  logic start;
  logic stop;
  logic pause;
  logic cfg_write;
  logic [1:0] cfg_channel;
  logic [PERIOD_WIDTH-1:0] cfg_period;

  assign clk         = SC_TICKSCHED_CLOCK_50;
  assign rst         = SC_TICKSCHED_RESET_InHigh;
  assign start       = SC_TICKSCHED_start_InHigh;
  assign stop        = SC_TICKSCHED_stop_InHigh;
  assign pause       = SC_TICKSCHED_pause_InHigh;
  assign cfg_write   = SC_TICKSCHED_cfgWrite_InHigh;
  assign cfg_channel = SC_TICKSCHED_cfgChannel_In;
  assign cfg_period  = SC_TICKSCHED_cfgPeriod_In;

  state_t state_reg, state_next;
  logic [PRESCALE_WIDTH-1:0] prescaler_reg, prescaler_next;
  logic base_tick;

  logic [PERIOD_WIDTH-1:0] period_reg   [4];
  logic [PERIOD_WIDTH-1:0] period_next  [4];
  logic [PERIOD_WIDTH-1:0] subcount_reg [4];
  logic [PERIOD_WIDTH-1:0] subcount_next[4];
  logic [3:0] tick_reg, tick_next;

  // State and prescaler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      prescaler_reg <= '0;
    end else begin
      state_reg     <= state_next;
      prescaler_reg <= prescaler_next;
    end
  end

  // Next state and prescaler. The prescaler advances on every RUN cycle,
  // including the cycle in which pause is first seen, so a pause starting
  // on a base event still lets that event count. PAUSE simply holds.
  always_comb begin
    state_next     = state_reg;
    prescaler_next = prescaler_reg;
    case (state_reg)
      IDLE: begin
        prescaler_next = '0;
        if (start && !stop) state_next = RUN;
      end
      RUN: begin
        if (stop) begin
          state_next     = IDLE;
          prescaler_next = '0;
        end else begin
          prescaler_next = prescaler_reg + 1'b1;
          if (pause) state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_next     = IDLE;
          prescaler_next = '0;
        end else if (!pause) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next     = IDLE;
        prescaler_next = '0;
      end
    endcase
  end

  assign base_tick = (state_reg == RUN) && (&prescaler_reg);

  // Channel logic. A config write to a channel overrides whatever the base
  // event would have done to it; stop clears phase but keeps the period.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    logic wr_hit;
    logic wrap;
    logic active;

    assign wr_hit = cfg_write && (cfg_channel == 2'(gi));
    assign active = base_tick && (period_reg[gi] != '0);
    assign wrap   = (subcount_reg[gi] == period_reg[gi] - 1'b1);

    assign period_next[gi] = wr_hit ? cfg_period : period_reg[gi];

    assign subcount_next[gi] = (wr_hit || stop) ? '0 :
                               !active          ? subcount_reg[gi] :
                               wrap             ? '0 :
                                                  subcount_reg[gi] + 1'b1;

    assign tick_next[gi] = active && wrap && !wr_hit && !stop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_reg <= '0;
      for (int i = 0; i < 4; i++) begin
        period_reg[i]   <= '0;
        subcount_reg[i] <= '0;
      end
    end else begin
      tick_reg <= tick_next;
      for (int i = 0; i < 4; i++) begin
        period_reg[i]   <= period_next[i];
        subcount_reg[i] <= subcount_next[i];
      end
    end
  end

  assign SC_TICKSCHED_tick_Out     = tick_reg;
  assign SC_TICKSCHED_baseTick_Out = base_tick;
  assign SC_TICKSCHED_state_Out    = state_reg;

endmodule

// File: tb/tb_sc_tick_scheduler.sv
module tb_sc_tick_scheduler;

  localparam int PW   = 3;
  localparam int PERW = 4;
  localparam int BASE = 1 << PW;

  logic clk = 1'b0;
  logic rst;
  logic start, stop, pause, cfg_wr;
  logic [1:0] cfg_ch;
  logic [PERW-1:0] cfg_per;
  logic [3:0] tick_o;
  logic base_o;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  sc_tick_scheduler #(.PRESCALE_WIDTH(PW), .PERIOD_WIDTH(PERW)) dut (
    .SC_TICKSCHED_CLOCK_50       (clk),
    .SC_TICKSCHED_RESET_InHigh   (rst),
    .SC_TICKSCHED_start_InHigh   (start),
    .SC_TICKSCHED_stop_InHigh    (stop),
    .SC_TICKSCHED_pause_InHigh   (pause),
    .SC_TICKSCHED_cfgWrite_InHigh(cfg_wr),
    .SC_TICKSCHED_cfgChannel_In  (cfg_ch),
    .SC_TICKSCHED_cfgPeriod_In   (cfg_per),
    .SC_TICKSCHED_tick_Out       (tick_o),
    .SC_TICKSCHED_baseTick_Out   (base_o),
    .SC_TICKSCHED_state_Out      (state_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: time is tracked as RUN cycles elapsed since start,
  // and each channel as base events seen since its phase anchor.
  int m_state;      // 0 idle, 1 run, 2 pause
  int run_clks;
  int per [4];
  int evc [4];
  logic [3:0] m_tick;

  // Observed pulses accumulated per stimulus segment.
  int cnt_base;
  int cnt_t [4];
  logic obs_base;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    run_clks = 0;
    m_tick   = '0;
    for (int i = 0; i < 4; i++) begin
      per[i] = 0;
      evc[i] = 0;
    end
  endtask

  // One clock: drive inputs just after the rising edge, compare at the
  // falling edge, then advance the model across the next rising edge.
  task automatic step(input logic st, input logic sp, input logic pa,
                      input logic wr, input logic [1:0] ch, input logic [PERW-1:0] pv);
    logic exp_base;
    logic [3:0] nt;
    start = st; stop = sp; pause = pa; cfg_wr = wr; cfg_ch = ch; cfg_per = pv;
    exp_base = (m_state == 1) && ((run_clks % BASE) == BASE - 1);
    @(negedge clk);
    obs_base = base_o;
    chk("state", 32'(state_o), 32'(m_state));
    chk("baseTick", 32'(base_o), 32'(exp_base));
    chk("tick", 32'(tick_o), 32'(m_tick));
    if (base_o) cnt_base++;
    for (int i = 0; i < 4; i++) if (tick_o[i]) cnt_t[i]++;
    nt = '0;
    for (int i = 0; i < 4; i++) begin
      if (wr && ch == 2'(i)) begin
        per[i] = int'(pv);
        evc[i] = 0;
      end else if (sp) begin
        evc[i] = 0;
      end else if (exp_base && per[i] != 0) begin
        evc[i]++;
        if (evc[i] % per[i] == 0) nt[i] = 1'b1;
      end
    end
    if (sp) begin
      m_state  = 0;
      run_clks = 0;
    end else begin
      case (m_state)
        0: if (st) m_state = 1;
        1: begin
          run_clks++;
          if (pa) m_state = 2;
        end
        default: if (!pa) m_state = 1;
      endcase
    end
    m_tick = nt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0);
  endtask

  typedef struct {
    logic st, sp, pa, wr;
    logic [1:0] ch;
    logic [PERW-1:0] pv;
    int n;
    int e_state, e_base, e_t0, e_t1, e_t2, e_t3;
  } row_t;

  row_t rows [16];

  initial begin
    int k;
    logic found;

    rows[0]  = '{1'b0,1'b0,1'b0,1'b0,2'd0,4'd0,   1, 0, 0, 0, 0,0,0};
    rows[1]  = '{1'b0,1'b0,1'b0,1'b1,2'd0,4'd1,   1, 0, 0, 0, 0,0,0};
    rows[2]  = '{1'b0,1'b0,1'b0,1'b1,2'd1,4'd3,   1, 0, 0, 0, 0,0,0};
    rows[3]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,4'd0,   1, 0, 0, 0, 0,0,0};
    rows[4]  = '{1'b1,1'b0,1'b0,1'b0,2'd0,4'd0,   1, 0, 0, 0, 0,0,0};
    rows[5]  = '{1'b0,1'b0,1'b0,1'b0,2'd0,4'd0,  49, 1, 6, 6, 2,0,0};
    rows[6]  = '{1'b1,1'b1,1'b1,1'b0,2'd0,4'd0,   1, 1, 0, 0, 0,0,0};
    rows[7]  = '{1'b0,1'b0,1'b0,1'b0,2'd0,4'd0,   3, 0, 0, 0, 0,0,0};
    rows[8]  = '{1'b1,1'b0,1'b0,1'b0,2'd0,4'd0,   1, 0, 0, 0, 0,0,0};
    rows[9]  = '{1'b0,1'b0,1'b0,1'b0,2'd0,4'd0,   8, 1, 1, 0, 0,0,0};
    rows[10] = '{1'b0,1'b0,1'b0,1'b0,2'd0,4'd0,  17, 1, 2, 3, 1,0,0};
    rows[11] = '{1'b0,1'b0,1'b0,1'b0,2'd0,4'd0,  22, 1, 2, 2, 0,0,0};
    rows[12] = '{1'b0,1'b0,1'b0,1'b1,2'd1,4'd2,   1, 1, 1, 0, 0,0,0};
    rows[13] = '{1'b0,1'b0,1'b0,1'b0,2'd0,4'd0,  17, 1, 2, 3, 1,0,0};
    rows[14] = '{1'b0,1'b0,1'b0,1'b1,2'd3,4'd15,  1, 1, 0, 0, 0,0,0};
    rows[15] = '{1'b0,1'b0,1'b0,1'b0,2'd0,4'd0, 240, 1,30,30,15,0,2};

    rst = 1'b1;
    start = 1'b0; stop = 1'b0; pause = 1'b0; cfg_wr = 1'b0;
    cfg_ch = '0; cfg_per = '0;
    model_reset();
    #2;
    chk("reset_outputs", {27'd0, state_o, base_o, tick_o}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven segments: held inputs for n cycles, pulse counts checked.
    for (int r = 0; r < 16; r++) begin
      cnt_base = 0;
      for (int i = 0; i < 4; i++) cnt_t[i] = 0;
      for (int c = 0; c < rows[r].n; c++)
        step(rows[r].st, rows[r].sp, rows[r].pa, rows[r].wr, rows[r].ch, rows[r].pv);
      chk($sformatf("row%0d_state", r), 32'(state_o), 32'(rows[r].e_state == 1 ? m_state : m_state));
      chk($sformatf("row%0d_base", r), 32'(cnt_base), 32'(rows[r].e_base));
      chk($sformatf("row%0d_t0", r), 32'(cnt_t[0]), 32'(rows[r].e_t0));
      chk($sformatf("row%0d_t1", r), 32'(cnt_t[1]), 32'(rows[r].e_t1));
      chk($sformatf("row%0d_t2", r), 32'(cnt_t[2]), 32'(rows[r].e_t2));
      chk($sformatf("row%0d_t3", r), 32'(cnt_t[3]), 32'(rows[r].e_t3));
    end

    // Pause for 20 cycles starting where the prescaler reads 3: the next
    // base event lands 3+20+1 cycles after pause was first sampled.
    k = 0;
    while ((run_clks % BASE) != 3 && k < 16) begin
      idle_step();
      k++;
    end
    chk("pause_align", 32'(run_clks % BASE), 32'd3);
    cnt_base = 0;
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, '0);
    chk("pause_state", 32'(state_o), 32'd2);
    chk("pause_no_base", 32'(cnt_base), 32'd0);
    found = 1'b0;
    k = 20;
    while (!found && k < 60) begin
      idle_step();
      if (obs_base) found = 1'b1;
      else k++;
    end
    chk("pause_resume_delay", 32'(k), 32'd24);
    found = 1'b0;
    k = 0;
    while (!found && k < 40) begin
      idle_step();
      k++;
      if (obs_base) found = 1'b1;
    end
    chk("pause_spacing", 32'(k), 32'd8);

    // Randomized operation against the model.
    begin
      logic lvl;
      lvl = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 29) == 0) lvl = ~lvl;
        step($urandom_range(0, 14) == 0, $urandom_range(0, 199) == 0, lvl,
             $urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)),
             PERW'($urandom_range(0, 15)));
      end
    end

    // Async reset in the middle of a tick[0] pulse.
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
    found = 1'b0;
    k = 0;
    while (!found && k < 30) begin
      idle_step();
      k++;
      if (tick_o[0]) found = 1'b1;
    end
    chk("tick0_seen", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_tick", 32'(tick_o), 32'd0);
    chk("async_base", 32'(base_o), 32'd0);
    chk("async_state", 32'(state_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
    cnt_base = 0;
    for (int i = 0; i < 4; i++) cnt_t[i] = 0;
    for (int c = 0; c < 40; c++) idle_step();
    chk("post_reset_run", 32'(state_o), 32'd1);
    chk("post_reset_base", 32'(cnt_base), 32'd5);
    chk("post_reset_ticks", 32'(cnt_t[0] + cnt_t[1] + cnt_t[2] + cnt_t[3]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sc_tick_scheduler.md
# sc_tick_scheduler

Game time-base scheduler: owns one shared free-running prescaler and hands its base tick out to four independent channels (player move, alien march, bullet step, explosion timer). Each channel has a programmable period in base ticks and emits a one-cycle tick pulse when that period elapses. A small run/pause/idle FSM gates the whole time base so the game can freeze and resume without losing phase.

## Interface

- PRESCALE_WIDTH, 21, prescaler width; base tick period = 2^PRESCALE_WIDTH clocks
- PERIOD_WIDTH, 4, width of each channel period register (periods 0..2^PERIOD_WIDTH-1)
- SC_TICKSCHED_CLOCK_50  in  1  system clock, all logic on rising edge
- SC_TICKSCHED_RESET_InHigh  in  1  asynchronous, active-high reset
- SC_TICKSCHED_start_InHigh  in  1  one-cycle pulse; IDLE -> RUN
- SC_TICKSCHED_stop_InHigh  in  1  one-cycle pulse; RUN/PAUSE -> IDLE
- SC_TICKSCHED_pause_InHigh  in  1  level; freezes time base while high in RUN
- SC_TICKSCHED_cfgWrite_InHigh  in  1  write strobe for channel period
- SC_TICKSCHED_cfgChannel_In  in  2  channel index for write
- SC_TICKSCHED_cfgPeriod_In  in  PERIOD_WIDTH  period value; 0 disables channel
- SC_TICKSCHED_tick_Out  out  4  per-channel one-cycle tick pulses, registered
- SC_TICKSCHED_baseTick_Out  out  1  high while prescaler == all-ones and state RUN
- SC_TICKSCHED_state_Out  out  2  IDLE=00, RUN=01, PAUSE=10

## Operation

- Reset: state IDLE, prescaler 0, all subcounters 0, all periods 0, tick_Out 0, baseTick_Out 0.
- IDLE: prescaler and subcounters held at 0; no ticks. start -> RUN.
- RUN: prescaler +1 per clock, wraps all-ones -> 0. Base event = prescaler all-ones in RUN.
- PAUSE: prescaler, subcounters, periods' effect frozen; no base event, no ticks. pause low -> RUN.
- RUN with pause high -> PAUSE; start ignored outside IDLE.
- stop in RUN or PAUSE -> IDLE; prescaler and subcounters cleared; periods kept.
- Priority same cycle: stop > pause > start. stop+start in IDLE: stays IDLE.
- Per channel i on base event: if period[i]==0, subcounter held 0, no tick. Else if subcounter[i]==period[i]-1 -> tick[i] next cycle, subcounter 0; else subcounter +1.
- Config write (any state): period[cfgChannel] <= cfgPeriod, subcounter[cfgChannel] <= 0. Write coinciding with base event: write wins for that channel, no tick from it that event; other channels unaffected.
- Subcounter width PERIOD_WIDTH; never exceeds period-1, no overflow path.

## Timing

- Transitions take effect on the edge after the command; state_Out reflects new state in the next cycle.
- start at edge T: prescaler = 1 after edge T+1; first base event 2^PRESCALE_WIDTH clocks after start sampled.
- baseTick_Out combinational from prescaler + state, high exactly one cycle per wrap.
- tick_Out[i] registered: high the cycle after the qualifying baseTick_Out cycle, low otherwise; width exactly one cycle.
- Channel tick period = period[i] × 2^PRESCALE_WIDTH clocks in uninterrupted RUN.
- Pause of P cycles stretches the current interval by exactly P cycles (phase kept).
- pause raised in the base-event cycle: event still processed (state is RUN that cycle), freeze from the next edge.
- Async reset mid-operation: all outputs 0 immediately, independent of clock; state IDLE on release.

## Test plan

- PRESCALE_WIDTH=3; periods ch0=1, ch1=3; start -> baseTick_Out every 8 clocks; tick[0] every 8, one cycle after each baseTick; tick[1] every 24, first one cycle after third baseTick.
- Same setup, pause high 20 clocks at prescaler=4 -> no baseTick/tick, prescaler stays 4; resume -> next baseTick 3+20+1 clocks after pause edge, spacing then 8.
- stop+pause+start asserted together in RUN -> IDLE, prescaler 0, subcounters 0, no ticks; following start alone -> RUN.
- ch1 subcounter=2, period 3; write ch1 period 2 in baseTick cycle -> no tick[1], subcounter 0; next tick[1] after 2 base events (16 clocks).
- Period 0 on ch2 -> tick[2] never asserts over 200 clocks; ch3 period 15 -> tick[3] every 120 clocks.
- Async reset asserted between clock edges during tick[0] pulse -> tick_Out, baseTick_Out 0 and state_Out 00 immediately; periods read back 0 (no ticks after start).
